// File: rtl/bp_pkg.sv
// Shared definitions for the branch pattern table: counter limits and index hash.
package bp_pkg;

    // Largest value of a CTR_BITS-wide saturating counter (strongly taken).
    function automatic int unsigned ctr_max(input int unsigned ctr_bits);
        return (32'd1 << ctr_bits) - 32'd1;
    endfunction

    // Weakly-not-taken value: one below the taken threshold.
    function automatic int unsigned ctr_init(input int unsigned ctr_bits);
        return (32'd1 << (ctr_bits - 32'd1)) - 32'd1;
    endfunction

    // Table index from a word-aligned PC, optionally XORed with global history.
    // Inputs are zero-extended to fixed widths so the same function serves any
    // table size; the caller truncates the result to its own index width.
    function automatic logic [31:0] bp_index_hash(input logic [63:0]   pc,
                                                  input logic [31:0]   ghr_ext,
                                                  input int unsigned   index_bits,
                                                  input bit            use_ghr);
        logic [31:0] mask;
        logic [31:0] base;
        mask = (32'd1 << index_bits) - 32'd1;
        base = 32'(pc >> 2) & mask;
        if (use_ghr) begin
            base = base ^ (ghr_ext & mask);
        end
        return base;
    endfunction

endpackage

// File: rtl/bp_sat_counter_next.sv
// Next value of a saturating up/down counter; purely combinational.
// Ports: cur  - current counter value
//        taken - 1 = count up, 0 = count down
//        nxt  - updated value, clamped at 0 and at all-ones
module bp_sat_counter_next
    import bp_pkg::*;
#(
    parameter int unsigned CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] cur,
    input  logic                taken,
    output logic [CTR_BITS-1:0] nxt
);

    localparam logic [CTR_BITS-1:0] CTR_MAX = CTR_BITS'(ctr_max(CTR_BITS));

    // Step toward the outcome, holding at either end instead of wrapping.
    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != CTR_MAX) nxt = cur + CTR_BITS'(1);
        end else begin
            if (cur != '0) nxt = cur - CTR_BITS'(1);
        end
    end

endmodule

// File: rtl/bp_pattern_table.sv
// Branch direction predictor: table of saturating counters indexed by PC
// (bimodal) or PC XOR global history (gshare), with a mispredict statistic.
// Ports: clk, rst (sync, active-high)
//        pred_valid/pred_pc            - lookup request from fetch
//        pred_out_valid/pred_taken/pred_idx - registered lookup result (1 cycle)
//        upd_valid/upd_idx/upd_taken/upd_mispredict - training from execute
//        ghr                           - non-speculative global history
//        stat_mispred                  - saturating mispredict count
module bp_pattern_table
    import bp_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned CTR_BITS   = 2,
    parameter int unsigned GHR_BITS   = 6,
    parameter int unsigned USE_GHR    = 1,
    parameter int unsigned STAT_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pred_valid,
    input  logic [PC_WIDTH-1:0]   pred_pc,
    output logic                  pred_out_valid,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_idx,
    input  logic                  upd_valid,
    input  logic [INDEX_BITS-1:0] upd_idx,
    input  logic                  upd_taken,
    input  logic                  upd_mispredict,
    output logic [GHR_BITS-1:0]   ghr,
    output logic [STAT_BITS-1:0]  stat_mispred
);

    localparam int unsigned         ENTRIES  = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_init(CTR_BITS));

    logic [CTR_BITS-1:0]   table_q [ENTRIES];
    logic [INDEX_BITS-1:0] idx_c;
    logic [CTR_BITS-1:0]   upd_ctr_next_c;

    // Lookup index uses the history as it stands before any same-cycle shift.
    assign idx_c = INDEX_BITS'(bp_index_hash(64'(pred_pc), 32'(ghr),
                                             INDEX_BITS, USE_GHR != 0));

    bp_sat_counter_next #(
        .CTR_BITS (CTR_BITS)
    ) u_ctr_next (
        .cur   (table_q[upd_idx]),
        .taken (upd_taken),
        .nxt   (upd_ctr_next_c)
    );

    // Lookup result register; a missing request drops valid but keeps data.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_out_valid <= 1'b0;
            pred_taken     <= 1'b0;
            pred_idx       <= '0;
        end else begin
            pred_out_valid <= pred_valid;
            if (pred_valid) begin
                pred_taken <= table_q[idx_c][CTR_BITS-1];
                pred_idx   <= idx_c;
            end
        end
    end

    // Counter table; the lookup above reads the pre-update value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= CTR_INIT;
            end
        end else if (upd_valid) begin
            table_q[upd_idx] <= upd_ctr_next_c;
        end
    end

    // History shifts only on resolved branches; statistic saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr          <= '0;
            stat_mispred <= '0;
        end else if (upd_valid) begin
            ghr <= (ghr << 1) | GHR_BITS'(upd_taken);
            if (upd_mispredict && (stat_mispred != '1)) begin
                stat_mispred <= stat_mispred + STAT_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_bp_pattern_table.sv
// Self-checking bench: a gshare instance and a bimodal instance with a 2-bit
// statistic share one stimulus stream and are compared to an integer model.
module tb_bp_pattern_table;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        upd_valid;
    logic [5:0]  upd_idx;
    logic        upd_taken;
    logic        upd_mispredict;

    logic        pov_g, pt_g, pov_b, pt_b;
    logic [5:0]  pidx_g, pidx_b, ghr_g, ghr_b;
    logic [15:0] stat_g;
    logic [1:0]  stat_b;

    int errors = 0;
    int checks = 0;

    // Model state: plain integers, clamped arithmetic.
    int tbl_g [64];
    int tbl_b [64];
    int m_ghr, m_stat_g, m_stat_b;
    int e_pov_g, e_pt_g, e_pidx_g, e_pov_b, e_pt_b, e_pidx_b;

    always #5 clk = ~clk;

    bp_pattern_table #(.USE_GHR(1)) dut_g (
        .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_out_valid(pov_g), .pred_taken(pt_g), .pred_idx(pidx_g),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict), .ghr(ghr_g), .stat_mispred(stat_g)
    );

    bp_pattern_table #(.USE_GHR(0), .STAT_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_out_valid(pov_b), .pred_taken(pt_b), .pred_idx(pidx_b),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict), .ghr(ghr_b), .stat_mispred(stat_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            tbl_g[i] = 1;
            tbl_b[i] = 1;
        end
        m_ghr = 0; m_stat_g = 0; m_stat_b = 0;
        e_pov_g = 0; e_pt_g = 0; e_pidx_g = 0;
        e_pov_b = 0; e_pt_b = 0; e_pidx_b = 0;
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        int word, ig, ib;
        if (rst) begin
            model_reset();
            return;
        end
        word = int'(pred_pc / 4) % 64;
        ig = word ^ m_ghr;
        ib = word;
        e_pov_g = int'(pred_valid);
        e_pov_b = int'(pred_valid);
        if (pred_valid) begin
            e_pt_g = (tbl_g[ig] >= 2) ? 1 : 0; e_pidx_g = ig;
            e_pt_b = (tbl_b[ib] >= 2) ? 1 : 0; e_pidx_b = ib;
        end
        if (upd_valid) begin
            if (upd_taken) begin
                if (tbl_g[upd_idx] < 3) tbl_g[upd_idx] = tbl_g[upd_idx] + 1;
                if (tbl_b[upd_idx] < 3) tbl_b[upd_idx] = tbl_b[upd_idx] + 1;
            end else begin
                if (tbl_g[upd_idx] > 0) tbl_g[upd_idx] = tbl_g[upd_idx] - 1;
                if (tbl_b[upd_idx] > 0) tbl_b[upd_idx] = tbl_b[upd_idx] - 1;
            end
            m_ghr = (m_ghr * 2 + int'(upd_taken)) % 64;
            if (upd_mispredict) begin
                if (m_stat_g < 65535) m_stat_g++;
                if (m_stat_b < 3) m_stat_b++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pov_g"},  32'(pov_g),  32'(e_pov_g));
        chk({tag, ".pt_g"},   32'(pt_g),   32'(e_pt_g));
        chk({tag, ".pidx_g"}, 32'(pidx_g), 32'(e_pidx_g));
        chk({tag, ".pov_b"},  32'(pov_b),  32'(e_pov_b));
        chk({tag, ".pt_b"},   32'(pt_b),   32'(e_pt_b));
        chk({tag, ".pidx_b"}, 32'(pidx_b), 32'(e_pidx_b));
        chk({tag, ".ghr_g"},  32'(ghr_g),  32'(m_ghr));
        chk({tag, ".ghr_b"},  32'(ghr_b),  32'(m_ghr));
        chk({tag, ".stat_g"}, 32'(stat_g), 32'(m_stat_g));
        chk({tag, ".stat_b"}, 32'(stat_b), 32'(m_stat_b));
    endtask

    // Drive one cycle of inputs, clock, advance model, compare.
    task automatic step(input string tag, input logic r, input logic pv, input logic [31:0] pc,
                        input logic uv, input logic [5:0] ui, input logic ut, input logic um);
        rst = r; pred_valid = pv; pred_pc = pc;
        upd_valid = uv; upd_idx = ui; upd_taken = ut; upd_mispredict = um;
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1; pred_valid = 1'b0; pred_pc = '0;
        upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
        model_reset();
        #1;
        step("reset0", 1, 0, 0, 0, 0, 0, 0);
        step("reset1", 1, 0, 0, 0, 0, 0, 0);

        // First lookup after reset: weakly not taken, idx 0x10 with ghr 0.
        step("lookup40", 0, 1, 32'h40, 0, 0, 0, 0);
        chk("first_idx", 32'(pidx_g), 32'h10);
        chk("first_taken", 32'(pt_g), 32'h0);
        step("idle", 0, 0, 32'h80, 0, 0, 0, 0);

        // Train idx 0x10 up to strongly taken, then past saturation.
        for (int i = 0; i < 2; i++) step("tr_up", 0, 0, 0, 1, 6'h10, 1, 0);
        step("lookup_up", 0, 1, 32'h40, 0, 0, 0, 0);
        chk("bimodal_taken", 32'(pt_b), 32'h1);
        for (int i = 0; i < 3; i++) step("tr_sat", 0, 1, 32'h40, 1, 6'h10, 1, 0);
        for (int i = 0; i < 4; i++) step("tr_dn", 0, 1, 32'h40, 1, 6'h10, 0, 0);
        step("lookup_dn", 0, 1, 32'h40, 0, 0, 0, 0);
        chk("no_wrap", 32'(pt_b), 32'h0);

        // Six taken updates fill the history; gshare index becomes 0x10^0x3F.
        for (int i = 0; i < 6; i++) step("ghr_fill", 0, 0, 0, 1, 6'h20, 1, 0);
        step("gshare", 0, 1, 32'h40, 0, 0, 0, 0);
        chk("gshare_idx", 32'(pidx_g), 32'h2F);

        // Same-cycle lookup and update on idx 5: lookup sees old counter.
        step("rbw0", 0, 1, 32'h14, 1, 6'h05, 1, 0);
        chk("rbw_old", 32'(pt_b), 32'h0);
        step("rbw1", 0, 1, 32'h14, 0, 0, 0, 0);
        chk("rbw_new", 32'(pt_b), 32'h1);

        // Mispredict statistic saturates on the 2-bit instance.
        for (int i = 0; i < 5; i++) step("stat", 0, 0, 0, 1, 6'h07, 0, 1);
        chk("stat_sat", 32'(stat_b), 32'h3);
        step("stat_noupd", 0, 0, 0, 0, 6'h07, 0, 1);

        // Reset wins over same-cycle lookup and update; table returns to 01.
        for (int i = 0; i < 2; i++) step("pre_rst", 0, 0, 0, 1, 6'h10, 1, 0);
        step("rst_pri", 1, 1, 32'h40, 1, 6'h10, 1, 1);
        chk("rst_pov", 32'(pov_g), 32'h0);
        chk("rst_ghr", 32'(ghr_g), 32'h0);
        step("post_rst_dn", 0, 0, 0, 1, 6'h10, 0, 0);
        step("post_rst_lk", 0, 1, 32'h40, 0, 0, 0, 0);
        chk("rst_entry", 32'(pt_b), 32'h0);

        // Random traffic concentrated on a few entries to exercise saturation.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] pc;
            pc = {$urandom_range(0, 255), 2'b00} | ($urandom & 32'hFFFF_FC00);
            step("rand", ($urandom_range(0, 60) == 0), 1'($urandom), pc,
                 1'($urandom), 6'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
